// File: rtl/exec_datapath_if.sv
// Decoder-to-execute bus for exec_datapath: register file ports,
// operand sources, ALU control and ALU result/flag.
interface exec_datapath_if #(
    parameter int CPU_WIDTH     = 32,
    parameter int EXU_OPT_WIDTH = 4,
    parameter int EXU_SEL_WIDTH = 3
);
    logic                     wr_en_Rd;
    logic [4:0]               addr_Rd;
    logic [CPU_WIDTH-1:0]     data_Rd;
    logic [4:0]               addr_Rs1;
    logic [4:0]               addr_Rs2;
    logic [CPU_WIDTH-1:0]     data_Rs1;
    logic [CPU_WIDTH-1:0]     data_Rs2;
    logic [CPU_WIDTH-1:0]     pc;
    logic [CPU_WIDTH-1:0]     imm;
    logic [EXU_OPT_WIDTH-1:0] exu_opt_code;
    logic [EXU_SEL_WIDTH-1:0] exu_sel_code;
    logic [CPU_WIDTH-1:0]     exu_res;
    logic                     zero;

    // Decoder / downstream side
    modport master (
        output wr_en_Rd, addr_Rd, data_Rd, addr_Rs1, addr_Rs2,
               pc, imm, exu_opt_code, exu_sel_code,
        input  data_Rs1, data_Rs2, exu_res, zero
    );

    // Datapath side
    modport slave (
        input  wr_en_Rd, addr_Rd, data_Rd, addr_Rs1, addr_Rs2,
               pc, imm, exu_opt_code, exu_sel_code,
        output data_Rs1, data_Rs2, exu_res, zero
    );
endinterface

// File: rtl/exec_datapath.sv
// Execute-stage datapath: reset synchroniser, GPR file (x0 = 0) and
// combinational ALU with operand-select mux and branch flag.
// Optional macro GPR_RV32E_EN: 16-entry register file; accesses with
// address bit 4 set read 0 / are dropped.
module exec_datapath #(
    parameter int CPU_WIDTH     = 32,
    parameter int EXU_OPT_WIDTH = 4,
    parameter int EXU_SEL_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             rstn_sync,
    exec_datapath_if.slave   bus
);

`ifdef GPR_RV32E_EN
    localparam int NREG = 16;
    localparam int AW   = 4;
`else
    localparam int NREG = 32;
    localparam int AW   = 5;
`endif

    logic                 rstn_sync_q;
    logic [CPU_WIDTH-1:0] rf_q [NREG];
    logic                 wr_ok, rd1_ok, rd2_ok;
    logic [AW-1:0]        wr_idx, rd1_idx, rd2_idx;
    logic [CPU_WIDTH-1:0] op_a, op_b, res_d;
    logic [4:0]           shamt;
    logic                 lt_s, lt_u;

    // Release from reset one clock after rstn rises; assert immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rstn_sync_q <= 1'b0;
        else       rstn_sync_q <= 1'b1;
    end
    assign rstn_sync = rstn_sync_q;

    assign wr_idx  = bus.addr_Rd[AW-1:0];
    assign rd1_idx = bus.addr_Rs1[AW-1:0];
    assign rd2_idx = bus.addr_Rs2[AW-1:0];

`ifdef GPR_RV32E_EN
    // Upper half of the architectural space does not exist
    assign wr_ok  = (bus.addr_Rd  != 5'd0) && !bus.addr_Rd[4];
    assign rd1_ok = (bus.addr_Rs1 != 5'd0) && !bus.addr_Rs1[4];
    assign rd2_ok = (bus.addr_Rs2 != 5'd0) && !bus.addr_Rs2[4];
`else
    assign wr_ok  = (bus.addr_Rd  != 5'd0);
    assign rd1_ok = (bus.addr_Rs1 != 5'd0);
    assign rd2_ok = (bus.addr_Rs2 != 5'd0);
`endif

    // Register file: async clear; writes gated by the synchronised reset
    // so the edge that releases rstn cannot corrupt state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (bus.wr_en_Rd && rstn_sync_q && wr_ok) begin
            rf_q[wr_idx] <= bus.data_Rd;
        end
    end

    // Read ports: no bypass, old value is seen during a write cycle
    assign bus.data_Rs1 = rd1_ok ? rf_q[rd1_idx] : '0;
    assign bus.data_Rs2 = rd2_ok ? rf_q[rd2_idx] : '0;

    // Operand select
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (bus.exu_sel_code)
            3'd0: begin op_a = bus.data_Rs1; op_b = bus.data_Rs2; end
            3'd1: begin op_a = bus.data_Rs1; op_b = bus.imm;      end
            3'd2: begin op_a = bus.pc;       op_b = CPU_WIDTH'(4); end
            3'd3: begin op_a = '0;           op_b = bus.imm;      end
            3'd4: begin op_a = bus.pc;       op_b = bus.imm;      end
            default: ;
        endcase
    end

    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;

    // ALU; branch ops yield 0 when taken so zero=1 means "take branch"
    always_comb begin
        res_d = '0;
        case (bus.exu_opt_code)
            4'd0:  res_d = op_a + op_b;
            4'd1:  res_d = op_a - op_b;
            4'd2:  res_d = op_a << shamt;
            4'd3:  res_d = CPU_WIDTH'(lt_s);
            4'd4:  res_d = CPU_WIDTH'(lt_u);
            4'd5:  res_d = op_a ^ op_b;
            4'd6:  res_d = op_a >> shamt;
            4'd7:  res_d = CPU_WIDTH'($signed(op_a) >>> shamt);
            4'd8:  res_d = op_a | op_b;
            4'd9:  res_d = op_a & op_b;
            4'd10: res_d = CPU_WIDTH'(op_a != op_b);
            4'd11: res_d = CPU_WIDTH'(op_a == op_b);
            4'd12: res_d = CPU_WIDTH'(!lt_s);
            4'd13: res_d = CPU_WIDTH'(lt_s);
            4'd14: res_d = CPU_WIDTH'(!lt_u);
            4'd15: res_d = CPU_WIDTH'(lt_u);
            default: ;
        endcase
    end

    assign bus.exu_res = res_d;
    assign bus.zero    = (res_d == '0);

endmodule

// File: tb/tb_exec_datapath.sv
// Directed self-checking bench for exec_datapath.
module tb_exec_datapath;
    logic clk = 1'b0;
    logic rstn;
    logic rstn_sync;
    int   checks = 0;
    int   errors = 0;

    exec_datapath_if #(.CPU_WIDTH(32), .EXU_OPT_WIDTH(4), .EXU_SEL_WIDTH(3)) bus ();

    exec_datapath #(.CPU_WIDTH(32), .EXU_OPT_WIDTH(4), .EXU_SEL_WIDTH(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rstn_sync (rstn_sync),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Stimulus helpers (drive only)
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en_Rd = 1'b1; bus.addr_Rd = a; bus.data_Rd = d;
        @(posedge clk); #1;
        bus.wr_en_Rd = 1'b0;
    endtask

    task automatic set_alu(input logic [2:0] sel, input logic [3:0] opt);
        bus.exu_sel_code = sel; bus.exu_opt_code = opt;
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        bus.wr_en_Rd = 1'b0; bus.addr_Rd = '0; bus.data_Rd = '0;
        bus.addr_Rs1 = '0; bus.addr_Rs2 = '0; bus.pc = '0; bus.imm = '0;
        bus.exu_opt_code = '0; bus.exu_sel_code = '0;
        #1;
        checks++; if (rstn_sync !== 1'b0) begin errors++; $display("FAIL rst_sync_immediate got %b exp 0", rstn_sync); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rstn_sync !== 1'b0) begin errors++; $display("FAIL rst_sync_during got %b exp 0", rstn_sync); end
        @(negedge clk);
        rstn = 1'b1;
        bus.wr_en_Rd = 1'b1; bus.addr_Rd = 5'd3; bus.data_Rd = 32'h55;
        bus.addr_Rs1 = 5'd3;
        #1;
        checks++; if (rstn_sync !== 1'b0) begin errors++; $display("FAIL rst_sync_before_edge got %b exp 0", rstn_sync); end
        @(posedge clk); #1;
        bus.wr_en_Rd = 1'b0;
        checks++; if (rstn_sync !== 1'b1) begin errors++; $display("FAIL rst_sync_release got %b exp 1", rstn_sync); end
        checks++; if (bus.data_Rs1 !== 32'h0) begin errors++; $display("FAIL first_edge_write_dropped got %h exp 0", bus.data_Rs1); end
    endtask

    task automatic test_regfile;
        write_reg(5'd5, 32'hDEADBEEF);
        bus.addr_Rs1 = 5'd5; bus.addr_Rs2 = 5'd5; #1;
        checks++; if (bus.data_Rs1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_rs1_x5 got %h exp deadbeef", bus.data_Rs1); end
        checks++; if (bus.data_Rs2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_rs2_x5 got %h exp deadbeef", bus.data_Rs2); end
        write_reg(5'd0, 32'h1234);
        bus.addr_Rs1 = 5'd0; #1;
        checks++; if (bus.data_Rs1 !== 32'h0) begin errors++; $display("FAIL rf_x0 got %h exp 0", bus.data_Rs1); end
        write_reg(5'd7, 32'h11);
        @(negedge clk);
        bus.wr_en_Rd = 1'b1; bus.addr_Rd = 5'd7; bus.data_Rd = 32'h22; bus.addr_Rs1 = 5'd7;
        #1;
        checks++; if (bus.data_Rs1 !== 32'h11) begin errors++; $display("FAIL rf_no_bypass got %h exp 11", bus.data_Rs1); end
        @(posedge clk); #1;
        bus.wr_en_Rd = 1'b0;
        checks++; if (bus.data_Rs1 !== 32'h22) begin errors++; $display("FAIL rf_after_edge got %h exp 22", bus.data_Rs1); end
        // x5 untouched by other writes
        bus.addr_Rs2 = 5'd5; #1;
        checks++; if (bus.data_Rs2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_x5_kept got %h exp deadbeef", bus.data_Rs2); end
    endtask

    task automatic test_alu_arith;
        write_reg(5'd1, 32'h7FFFFFFF);
        write_reg(5'd2, 32'h1);
        bus.addr_Rs1 = 5'd1; bus.addr_Rs2 = 5'd2;
        set_alu(3'd0, 4'd0);
        checks++; if (bus.exu_res !== 32'h80000000) begin errors++; $display("FAIL add_ovf got %h exp 80000000", bus.exu_res); end
        set_alu(3'd0, 4'd1);
        checks++; if (bus.exu_res !== 32'h7FFFFFFE) begin errors++; $display("FAIL sub got %h exp 7ffffffe", bus.exu_res); end
        bus.addr_Rs1 = 5'd2; bus.addr_Rs2 = 5'd1;
        set_alu(3'd0, 4'd3);
        checks++; if (bus.exu_res !== 32'h1) begin errors++; $display("FAIL slt got %h exp 1", bus.exu_res); end
        set_alu(3'd0, 4'd9);
        checks++; if (bus.exu_res !== 32'h1) begin errors++; $display("FAIL and got %h exp 1", bus.exu_res); end
        set_alu(3'd0, 4'd5);
        checks++; if (bus.exu_res !== 32'h7FFFFFFE) begin errors++; $display("FAIL xor got %h exp 7ffffffe", bus.exu_res); end
        write_reg(5'd1, 32'hFFFFFFFF);
        bus.addr_Rs1 = 5'd1; bus.addr_Rs2 = 5'd2;
        set_alu(3'd0, 4'd4);
        checks++; if (bus.exu_res !== 32'h0) begin errors++; $display("FAIL sltu got %h exp 0", bus.exu_res); end
        set_alu(3'd0, 4'd0);
        checks++; if (bus.exu_res !== 32'h0 || bus.zero !== 1'b1) begin errors++; $display("FAIL add_wrap got %h/%b exp 0/1", bus.exu_res, bus.zero); end
        set_alu(3'd0, 4'd8);
        checks++; if (bus.exu_res !== 32'hFFFFFFFF || bus.zero !== 1'b0) begin errors++; $display("FAIL or got %h/%b exp ffffffff/0", bus.exu_res, bus.zero); end
    endtask

    task automatic test_shifts;
        write_reg(5'd1, 32'h80000000);
        bus.addr_Rs1 = 5'd1; bus.imm = 32'h24;
        set_alu(3'd1, 4'd7);
        checks++; if (bus.exu_res !== 32'hF8000000) begin errors++; $display("FAIL sra got %h exp f8000000", bus.exu_res); end
        set_alu(3'd1, 4'd6);
        checks++; if (bus.exu_res !== 32'h08000000) begin errors++; $display("FAIL srl got %h exp 08000000", bus.exu_res); end
        set_alu(3'd1, 4'd2);
        checks++; if (bus.exu_res !== 32'h0 || bus.zero !== 1'b1) begin errors++; $display("FAIL sll got %h/%b exp 0/1", bus.exu_res, bus.zero); end
    endtask

    task automatic test_opsel;
        bus.pc = 32'h80000010; bus.imm = 32'hFFFFFFF0;
        set_alu(3'd2, 4'd0);
        checks++; if (bus.exu_res !== 32'h80000014) begin errors++; $display("FAIL sel2_link got %h exp 80000014", bus.exu_res); end
        set_alu(3'd4, 4'd0);
        checks++; if (bus.exu_res !== 32'h80000000) begin errors++; $display("FAIL sel4_target got %h exp 80000000", bus.exu_res); end
        set_alu(3'd3, 4'd0);
        checks++; if (bus.exu_res !== 32'hFFFFFFF0) begin errors++; $display("FAIL sel3_lui got %h exp fffffff0", bus.exu_res); end
        set_alu(3'd6, 4'd8);
        checks++; if (bus.exu_res !== 32'h0 || bus.zero !== 1'b1) begin errors++; $display("FAIL sel6_zero got %h/%b exp 0/1", bus.exu_res, bus.zero); end
    endtask

    task automatic test_branch;
        write_reg(5'd1, 32'hFFFFFFFF);
        bus.addr_Rs1 = 5'd1; bus.addr_Rs2 = 5'd2;
        set_alu(3'd0, 4'd10);
        checks++; if (bus.zero !== 1'b0 || bus.exu_res !== 32'h1) begin errors++; $display("FAIL beq got %h/%b exp 1/0", bus.exu_res, bus.zero); end
        set_alu(3'd0, 4'd11);
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL bne got %b exp 1", bus.zero); end
        set_alu(3'd0, 4'd12);
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL blt got %b exp 1", bus.zero); end
        set_alu(3'd0, 4'd14);
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL bltu got %b exp 0", bus.zero); end
        set_alu(3'd0, 4'd13);
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL bge got %b exp 0", bus.zero); end
        set_alu(3'd0, 4'd15);
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL bgeu got %b exp 1", bus.zero); end
    endtask

    task automatic test_midreset;
        @(negedge clk);
        #2;
        rstn = 1'b0;
        bus.addr_Rs1 = 5'd5; bus.imm = 32'hA5A5A5A5;
        set_alu(3'd3, 4'd0);
        checks++; if (rstn_sync !== 1'b0) begin errors++; $display("FAIL midrst_sync got %b exp 0", rstn_sync); end
        checks++; if (bus.data_Rs1 !== 32'h0) begin errors++; $display("FAIL midrst_x5 got %h exp 0", bus.data_Rs1); end
        checks++; if (bus.exu_res !== 32'hA5A5A5A5) begin errors++; $display("FAIL midrst_alu got %h exp a5a5a5a5", bus.exu_res); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (rstn_sync !== 1'b1) begin errors++; $display("FAIL midrst_release got %b exp 1", rstn_sync); end
        write_reg(5'd5, 32'h600D);
        checks++; if (bus.data_Rs1 !== 32'h600D) begin errors++; $display("FAIL post_rst_write got %h exp 600d", bus.data_Rs1); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_alu_arith();
        test_shifts();
        test_opsel();
        test_branch();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
